// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module : seg_scan_pkg
// Brief  : Shared constants and helpers for the seven-segment scan path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int MAX_DIGITS  = 32;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
// ============================================================================
// Module : scan_prescaler
// Brief  : Refresh-rate counter; tick marks the last clk of each digit slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE = 25000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int c_CNT_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PRESCALE - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Combinational so the index advances on the same edge the count wraps.
    assign tick = enable && (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/digit_scan_mux.sv
// ============================================================================
// Module : digit_scan_mux
// Brief  : Time-multiplexed digit scanner with snapshot, blanking and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_scan_mux
    import seg_scan_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = DIGIT_W_DEF,
    parameter  int PRESCALE   = 25000,
    localparam int SEL_W      = clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic                          enable,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [SEL_W-1:0]              digit_idx,
    output logic                          scan_tick
);

    localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(NUM_DIGITS - 1);

    logic                          w_tick;
    logic [SEL_W-1:0]              idx_q;
    logic [SEL_W-1:0]              idx_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_q;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_d;
    logic [DIGIT_W-1:0]            digit_out_q;
    logic [DIGIT_W-1:0]            digit_out_d;
    logic [NUM_DIGITS-1:0]         anode_n_q;
    logic [NUM_DIGITS-1:0]         anode_n_d;
    logic [SEL_W-1:0]              digit_idx_q;
    logic                          scan_tick_q;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (w_tick)
    );

    // Explicit wrap keeps non-power-of-two digit counts from visiting unused indices.
    always_comb begin
        idx_d = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == c_LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        end
    end

    assign snap_d = load ? data_in : snap_q;

    // At most one anode can match idx_q, so the vector is one-hot or all dark.
    always_comb begin
        anode_n_d   = ANODE_OFF[NUM_DIGITS-1:0];
        digit_out_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((idx_q == SEL_W'(k)) && enable && !blank_mask[k]) begin
                anode_n_d[k] = 1'b0;
                digit_out_d  = snap_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            snap_q      <= '0;
            digit_out_q <= '0;
            anode_n_q   <= ANODE_OFF[NUM_DIGITS-1:0];
            digit_idx_q <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            digit_out_q <= digit_out_d;
            anode_n_q   <= anode_n_d;
            digit_idx_q <= idx_q;
            scan_tick_q <= w_tick;
        end
    end

    assign digit_out = digit_out_q;
    assign anode_n   = anode_n_q;
    assign digit_idx = digit_idx_q;
    assign scan_tick = scan_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
// ============================================================================
// Module : tb_digit_scan_mux
// Brief  : Self-checking bench for digit_scan_mux (4 digits/PRESCALE 4 and
//          3 digits/PRESCALE 1) against a slot-arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digit_scan_mux;

    logic        clk;
    logic        reset_n;

    logic        en_a, load_a;
    logic [15:0] data_a;
    logic [3:0]  mask_a;
    logic [3:0]  a_digit;
    logic [3:0]  a_anode;
    logic [1:0]  a_idx;
    logic        a_tick;

    logic        en_b, load_b;
    logic [11:0] data_b;
    logic [2:0]  mask_b;
    logic [3:0]  b_digit;
    logic [2:0]  b_anode;
    logic [1:0]  b_idx;
    logic        b_tick;

    int          n_checks;
    int          n_errors;
    string       phase;

    // Reference state: enabled-cycle count and the snapshot contents.
    int          a_cnt, b_cnt;
    logic [15:0] a_snap, b_snap;
    logic [3:0]  ea_digit, ea_anode, eb_digit, eb_anode;
    int          ea_idx, eb_idx;
    logic        ea_tick, eb_tick;

    digit_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .PRESCALE(4)) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_a),
        .load       (load_a),
        .blank_mask (mask_a),
        .enable     (en_a),
        .digit_out  (a_digit),
        .anode_n    (a_anode),
        .digit_idx  (a_idx),
        .scan_tick  (a_tick)
    );

    digit_scan_mux #(.NUM_DIGITS(3), .DIGIT_W(4), .PRESCALE(1)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_b),
        .load       (load_b),
        .blank_mask (mask_b),
        .enable     (en_b),
        .digit_out  (b_digit),
        .anode_n    (b_anode),
        .digit_idx  (b_idx),
        .scan_tick  (b_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%s] got=%0h want=%0h t=%0t", tag, phase, act, exp, $time);
        end
    endtask

    // Slot k of the scan covers enabled cycles [k*p, (k+1)*p); index = slot mod n.
    task automatic model_step(input int n, input int p, input logic en, input logic ld,
                              input logic [15:0] data, input logic [3:0] mask,
                              inout int cnt, inout logic [15:0] snap,
                              output logic [3:0] e_digit, output logic [3:0] e_anode,
                              output int e_idx, output logic e_tick);
        int idx;
        idx     = (cnt / p) % n;
        e_idx   = idx;
        e_anode = 4'hF;
        e_digit = 4'h0;
        e_tick  = en && ((cnt % p) == (p - 1));
        if (en && !mask[idx]) begin
            e_anode[idx] = 1'b0;
            e_digit      = snap[idx*4 +: 4];
        end
        if (en) cnt = cnt + 1;
        if (ld) snap = data;
    endtask

    task automatic model_reset();
        a_cnt = 0;  a_snap = '0; ea_digit = '0; ea_anode = 4'hF; ea_idx = 0; ea_tick = 1'b0;
        b_cnt = 0;  b_snap = '0; eb_digit = '0; eb_anode = 4'hF; eb_idx = 0; eb_tick = 1'b0;
    endtask

    task automatic compare_all();
        chk("A.digit",  32'(a_digit), 32'(ea_digit));
        chk("A.anode",  32'(a_anode), 32'(ea_anode));
        chk("A.idx",    32'(a_idx),   32'(ea_idx));
        chk("A.tick",   32'(a_tick),  32'(ea_tick));
        chk("A.onehot", 32'($countones(~a_anode) <= 1), 32'd1);
        chk("B.digit",  32'(b_digit), 32'(eb_digit));
        chk("B.anode",  32'(b_anode), 32'(eb_anode[2:0]));
        chk("B.idx",    32'(b_idx),   32'(eb_idx));
        chk("B.tick",   32'(b_tick),  32'(eb_tick));
        chk("B.onehot", 32'($countones(~b_anode) <= 1), 32'd1);
        chk("B.idx_range", 32'(b_idx < 2'd3), 32'd1);
    endtask

    // Inputs are stable at the rising edge; outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) begin
            model_step(4, 4, en_a, load_a, data_a, mask_a, a_cnt, a_snap,
                       ea_digit, ea_anode, ea_idx, ea_tick);
            model_step(3, 1, en_b, load_b, {4'h0, data_b}, {1'b0, mask_b}, b_cnt, b_snap,
                       eb_digit, eb_anode, eb_idx, eb_tick);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        phase    = "reset";
        reset_n  = 1'b0;
        en_a = 1'b0; load_a = 1'b0; data_a = '0; mask_a = '0;
        en_b = 1'b0; load_b = 1'b0; data_b = '0; mask_b = '0;
        model_reset();
        repeat (3) cycle();
        reset_n = 1'b1;

        phase = "idle";
        repeat (10) cycle();

        phase  = "scan";
        data_a = 16'h4321; load_a = 1'b1; en_a = 1'b1;
        data_b = 12'h987;  load_b = 1'b1; en_b = 1'b1;
        cycle();
        load_a = 1'b0; load_b = 1'b0;
        repeat (20) cycle();

        phase = "reload";
        for (int g = 0; g < 40; g++) begin
            if (((a_cnt / 4) % 4 == 1) && (a_cnt % 4 == 1)) break;
            cycle();
        end
        data_a = 16'hABCD; load_a = 1'b1;
        cycle();
        load_a = 1'b0;
        repeat (16) cycle();

        phase  = "blank";
        mask_a = 4'b0100; mask_b = 3'b010;
        repeat (20) cycle();
        mask_a = 4'b0000; mask_b = 3'b000;

        phase = "pause";
        en_a = 1'b0; en_b = 1'b0;
        repeat (5) cycle();
        en_a = 1'b1; en_b = 1'b1;
        repeat (6) cycle();

        phase = "midreset";
        for (int g = 0; g < 40; g++) begin
            if ((a_cnt / 4) % 4 == 3) break;
            cycle();
        end
        reset_pulse();
        repeat (20) cycle();

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            en_a   = ($urandom_range(0, 3) != 0);
            load_a = ($urandom_range(0, 4) == 0);
            data_a = 16'($urandom);
            mask_a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            en_b   = ($urandom_range(0, 3) != 0);
            load_b = ($urandom_range(0, 4) == 0);
            data_b = 12'($urandom);
            mask_b = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'h0;
            if (i == 170 || i == 340) reset_pulse();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
